// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian words from a byte stream and writes them at 4*i.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing cpu_hold.
module imem_loader #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd4,
`endif
    DONE  = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  idx_inc;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic              byte_ready_q, byte_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
  logic              err_q, err_d;
`endif

  assign hs      = byte_valid & byte_ready_q;
  assign idx_inc = idx_q + CNT_W'(1);

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    bidx_d       = bidx_q;
    word_d       = word_q;
    byte_ready_d = byte_ready_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    cpu_hold_d   = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d        = acc_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d  = {CNT_W{1'b0}};
          bidx_d = 2'd0;
          word_d = 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_d  = 8'd0;
          err_d  = 1'b0;
`endif
          if (word_count == {CNT_W{1'b0}}) begin
            state_d      = DONE;
            byte_ready_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            cpu_hold_d   = 1'b0;
          end else begin
            state_d      = RECV;
            cnt_d        = word_count;
            byte_ready_d = 1'b1;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            cpu_hold_d   = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      RECV: begin
        if (hs) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_d = acc_q ^ byte_data;
`endif
          if (bidx_q == 2'd3) begin
            state_d      = WRITE;
            byte_ready_d = 1'b0;
            wr_en_d      = 1'b1;
            wr_addr_d    = ADDR_W'({idx_q, 2'b00});
            wr_data_d    = {byte_data, word_q};
            bidx_d       = 2'd0;
          end else begin
            case (bidx_q)
              2'd0:    word_d[7:0]   = byte_data;
              2'd1:    word_d[15:8]  = byte_data;
              2'd2:    word_d[23:16] = byte_data;
              default: word_d        = word_q;
            endcase
            bidx_d = bidx_q + 2'd1;
          end
        end else begin
          state_d = RECV;
        end
      end
      WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d      = CHECK;
          byte_ready_d = 1'b1;
`else
          state_d      = DONE;
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cpu_hold_d   = 1'b0;
`endif
        end else begin
          state_d      = RECV;
          byte_ready_d = 1'b1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (hs) begin
          state_d      = DONE;
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          if (byte_data == acc_q) begin
            err_d      = 1'b0;
            cpu_hold_d = 1'b0;
          end else begin
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end else begin
          state_d = CHECK;
        end
      end
`endif
      default: begin
        // Unreachable encodings fall back to a quiet, CPU-held idle.
        state_d      = IDLE;
        byte_ready_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        cpu_hold_d   = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset discards any partial word and re-holds the CPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {CNT_W{1'b0}};
      bidx_q       <= 2'd0;
      word_q       <= 24'd0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q        <= 8'd0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_hold_q   <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q        <= acc_d;
      err_q        <= err_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_hold   = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the CPU's instruction memory. Fetch only reads imem; this block fills it before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to the imem write port at byte address 4*i, matching the fetch PC's +4 stride.
- Holds the CPU in reset (cpu_hold) until the load completes.

Parameters:
ADDR_W, 64, width of wr_addr (matches 64-bit PC)
CNT_W, 16, width of word_count and internal word index

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load; sampled only in IDLE or DONE
word_count  input  CNT_W  number of 32-bit words to load; sampled with start
byte_valid  input  1  source has a byte on byte_data
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  imem write strobe, one cycle per word
wr_addr  output  ADDR_W  imem byte address, always a multiple of 4
wr_data  output  32  instruction word
busy  output  1  load in progress
done  output  1  load finished; held until the next start
err  output  1  checksum mismatch (optional feature only)
cpu_hold  output  1  drives the CPU reset; high until a successful load

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- All outputs are registered. Values on reset: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, cpu_hold=1. State goes to IDLE; byte index, word index and XOR accumulator go to 0.
- Reset mid-load: any partially assembled word is discarded. Words already written to imem are not touched. cpu_hold returns to 1.
- States: IDLE, RECV, WRITE, CHECK (feature only), DONE.
- IDLE, on start=1:
  - word_count=0: go to DONE next cycle with done=1, cpu_hold=0.
  - word_count>0: latch the count; word index=0, byte index=0, XOR=0; go to RECV with busy=1, cpu_hold=1, done=0.
- DONE: start=1 re-enters a load exactly as from IDLE; cpu_hold re-asserts the next cycle. start is ignored in RECV, WRITE and CHECK.
- RECV: byte_ready=1. A handshake is byte_valid && byte_ready at a rising edge.
  - Byte k (k=0..3) goes into wr_data[8k+7:8k]; the first byte is the LSB.
  - byte_valid while byte_ready=0 is ignored. byte_data is sampled only on a handshake.
  - Handshake on the 4th byte at edge N: in the cycle after edge N, state=WRITE, byte_ready=0, wr_en=1, wr_addr=4*index, wr_data=full word.
- WRITE: lasts exactly one cycle, then wr_en=0 and the index increments.
  - If index+1 == count: go to DONE (or CHECK with the feature).
  - Otherwise go to RECV.
- Throughput: at most one word per 5 cycles.
- Arithmetic: wr_addr = {index, 2'b00} zero-extended to ADDR_W. The index never wraps because a load stops at count; word_count=2^CNT_W-1 is legal.
- Entering DONE: busy=0, done=1, byte_ready=0, cpu_hold=0 (cpu_hold stays 1 if err=1).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Every accepted data byte is XORed into an 8-bit accumulator.
  - After the last WRITE the block enters CHECK with byte_ready=1 and accepts one checksum byte.
  - Checksum equals the accumulator: DONE, err=0, cpu_hold=0.
  - Checksum differs: DONE, err=1, cpu_hold stays 1.
  - err clears on reset or on the next start.
  - A word_count=0 load skips CHECK: accumulator 0, no checksum byte.
- Not defined: no CHECK state and no accumulator; err is tied to 0.

Test Plan:
1. reset=1 then release -> cpu_hold=1, byte_ready=0, wr_en=0, done=0, busy=0.
2. start, word_count=2, bytes 6F,F9,01,91, 00,00,00,14 sent back-to-back -> exactly two writes, one cycle each:
   - wr_addr=0, wr_data=0x9101F96F
   - wr_addr=4, wr_data=0x14000000
   - then done=1, cpu_hold=0, busy=0.
3. Same load with byte_valid toggling 1/0 every cycle, plus byte_valid=1 during the WRITE cycles -> identical writes, no extra bytes consumed, wr_en pulses exactly twice.
4. start with word_count=0 -> done=1 and cpu_hold=0 one cycle later, no wr_en.
5. Load 3 words, assert reset after the 6th byte -> all outputs return to reset values, no write for word 1 ever. A new 1-word load afterwards writes addr 0 correctly.
6. With IMEM_LOADER_CHECKSUM_EN: 1 word AA,BB,CC,DD.
   - Checksum byte 0x00 (AA^BB^CC^DD) -> err=0, cpu_hold=0.
   - Repeat with checksum 0x01 -> err=1, cpu_hold=1, done=1.
